frame_sequencer: RTL and testbench

//  Per-frame controller for the double-buffered framebuffer. It sequences clear -> render -> wait-vblank -> swap.
//  It drives the framebuffer clear_in/switch_in pulses and the rasterizer start, and watches framebuffer

---
 rtl/frame_sequencer_if.sv | 24 ++
 rtl/frame_sequencer.sv | 113 +++++++++++
 tb/tb_frame_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - framebuffer/rasterizer handshake bundle for frame_sequencer
interface frame_sequencer_if;
    logic fb_ready_in;
    logic fb_clear_out;
    logic fb_switch_out;
    logic render_start_out;
    logic render_done_in;

    modport master (
        input  fb_ready_in,
        input  render_done_in,
        output fb_clear_out,
        output fb_switch_out,
        output render_start_out
    );

    modport slave (
        output fb_ready_in,
        output render_done_in,
        input  fb_clear_out,
        input  fb_switch_out,
        input  render_start_out
    );
endinterface

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - per-frame clear/render/vblank/swap controller for the double-buffered framebuffer
module frame_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter bit VSYNC_POL   = 1'b0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   enable_in,
    input  logic                   vsync_in,
    frame_sequencer_if.master      fb_if,
    output logic                   busy_out,
    output logic [COUNT_WIDTH-1:0] frame_count_out,
    output logic [COUNT_WIDTH-1:0] dropped_count_out
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_CLEAR      = 3'd1;
    localparam logic [2:0] S_CLEAR_ACK  = 3'd2;
    localparam logic [2:0] S_CLEAR_WAIT = 3'd3;
    localparam logic [2:0] S_START      = 3'd4;
    localparam logic [2:0] S_RENDER     = 3'd5;
    localparam logic [2:0] S_WAIT_VSYNC = 3'd6;
    localparam logic [2:0] S_SWITCH     = 3'd7;

    localparam logic VS_IDLE = ~VSYNC_POL;

    logic [1:0]             rst_sync;
    logic                   rst_n;
    logic [SYNC_STAGES-1:0] vs_sync;
    logic                   vs_dly;
    logic                   vblank_edge;
    logic                   drop_edge;
    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic                   clear_nxt;
    logic                   switch_nxt;
    logic                   start_nxt;

    // Reset asserts immediately but releases two clocks later, in step with clk_in.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            vs_sync <= {SYNC_STAGES{VS_IDLE}};
            vs_dly  <= VS_IDLE;
        end else begin
            vs_sync <= {vs_sync[SYNC_STAGES-2:0], vsync_in};
            vs_dly  <= vs_sync[SYNC_STAGES-1];
        end
    end

    assign vblank_edge = (vs_sync[SYNC_STAGES-1] == VSYNC_POL) && (vs_dly != VSYNC_POL);
    assign drop_edge   = vblank_edge && (state != S_IDLE) && (state != S_WAIT_VSYNC);

    always_comb begin
        state_nxt  = state;
        clear_nxt  = 1'b0;
        switch_nxt = 1'b0;
        start_nxt  = 1'b0;
        case (state)
            S_IDLE:       if (enable_in) state_nxt = S_CLEAR;
            S_CLEAR: begin
                clear_nxt = 1'b1;
                state_nxt = S_CLEAR_ACK;
            end
            // Framebuffer still shows ready for one cycle after clear_in; skip it.
            S_CLEAR_ACK:  state_nxt = S_CLEAR_WAIT;
            S_CLEAR_WAIT: if (fb_if.fb_ready_in) state_nxt = S_START;
            S_START: begin
                start_nxt = 1'b1;
                state_nxt = S_RENDER;
            end
            S_RENDER:     if (fb_if.render_done_in) state_nxt = S_WAIT_VSYNC;
            S_WAIT_VSYNC: if (vblank_edge) state_nxt = S_SWITCH;
            S_SWITCH: begin
                switch_nxt = 1'b1;
                state_nxt  = enable_in ? S_CLEAR : S_IDLE;
            end
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= S_IDLE;
            fb_if.fb_clear_out     <= 1'b0;
            fb_if.fb_switch_out    <= 1'b0;
            fb_if.render_start_out <= 1'b0;
            busy_out               <= 1'b0;
            frame_count_out        <= '0;
            dropped_count_out      <= '0;
        end else begin
            state                  <= state_nxt;
            fb_if.fb_clear_out     <= clear_nxt;
            fb_if.fb_switch_out    <= switch_nxt;
            fb_if.render_start_out <= start_nxt;
            busy_out               <= (state_nxt != S_IDLE);
            if (switch_nxt) begin
                frame_count_out <= frame_count_out + COUNT_WIDTH'(1);
            end
            if (drop_edge && (dropped_count_out != {COUNT_WIDTH{1'b1}})) begin
                dropped_count_out <= dropped_count_out + COUNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - randomized and directed bench for frame_sequencer against a frame-level model
module tb_frame_sequencer;
    localparam int SS   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam int P_IDLE = 0, P_CLEAR = 1, P_CLEAR_ACK = 2, P_CLEAR_WAIT = 3;
    localparam int P_START = 4, P_RENDER = 5, P_WAIT = 6, P_SWITCH = 7;

    logic          clk = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          enable_in = 1'b0;
    logic          vsync_in = 1'b1;
    logic          busy_out;
    logic [CW-1:0] frame_count_out;
    logic [CW-1:0] dropped_count_out;

    frame_sequencer_if fb_if();

    frame_sequencer #(.SYNC_STAGES(SS), .VSYNC_POL(1'b0), .COUNT_WIDTH(CW)) dut (
        .clk_in(clk), .rst_n_in(rst_n_in), .enable_in(enable_in), .vsync_in(vsync_in),
        .fb_if(fb_if), .busy_out(busy_out),
        .frame_count_out(frame_count_out), .dropped_count_out(dropped_count_out)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int m_phase = P_IDLE, m_frames = 0, m_drops = 0, rst_age = 0;
    bit m_clr = 0, m_sw = 0, m_start = 0;
    bit h0 = 1, h1 = 1, h2 = 1;

    bit vs_auto = 0, vs_man = 1, noise = 0, done_level_mode = 0, done_lvl = 0, clr_pend = 0;
    int vs_per = 4, vs_ph = 0, rd_len = 5, fb_lo = 0, done_dly = 20, rs_cnt = 0, switches = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Frame-level reference: vblank edge from raw-sample history, counters as plain ints.
    task automatic model_step();
        bit e;
        if (!rst_n_in) begin
            m_phase = P_IDLE; m_frames = 0; m_drops = 0; rst_age = 0;
            m_clr = 0; m_sw = 0; m_start = 0; h0 = 1; h1 = 1; h2 = 1;
            return;
        end
        if (rst_age < 2) begin
            rst_age++;
            return;
        end
        e = (h1 == 1'b0) && (h2 == 1'b1);
        h2 = h1; h1 = h0; h0 = vsync_in;
        m_clr = 0; m_sw = 0; m_start = 0;
        if (e && m_phase != P_IDLE && m_phase != P_WAIT)
            m_drops = (m_drops == CMAX) ? CMAX : m_drops + 1;
        case (m_phase)
            P_IDLE:       if (enable_in) m_phase = P_CLEAR;
            P_CLEAR:      begin m_clr = 1; m_phase = P_CLEAR_ACK; end
            P_CLEAR_ACK:  m_phase = P_CLEAR_WAIT;
            P_CLEAR_WAIT: if (fb_if.fb_ready_in) m_phase = P_START;
            P_START:      begin m_start = 1; m_phase = P_RENDER; end
            P_RENDER:     if (fb_if.render_done_in) m_phase = P_WAIT;
            P_WAIT:       if (e) m_phase = P_SWITCH;
            default: begin
                m_sw = 1;
                m_frames = (m_frames + 1) % (CMAX + 1);
                m_phase = enable_in ? P_CLEAR : P_IDLE;
            end
        endcase
    endtask

    // Framebuffer, rasterizer and VGA stand-ins reacting to what the DUT drove last cycle.
    task automatic drive_inputs();
        bit pulse;
        pulse = 0;
        if (!rst_n_in) begin
            fb_lo = 0; clr_pend = 0; rs_cnt = 0; done_lvl = 0;
        end else begin
            if (clr_pend) begin fb_lo = rd_len; clr_pend = 0; end
            if (fb_if.fb_clear_out) clr_pend = 1;
            if (fb_if.render_start_out) begin
                rs_cnt = done_dly; done_lvl = 0;
            end else if (rs_cnt > 0) begin
                rs_cnt--;
                if (rs_cnt == 0) begin pulse = 1; if (done_level_mode) done_lvl = 1; end
            end
        end
        fb_if.fb_ready_in = (fb_lo == 0);
        if (fb_lo > 0) fb_lo--;
        fb_if.render_done_in = pulse | done_lvl | (noise && $urandom_range(0, 49) == 0);
        if (vs_auto) begin
            vs_ph = (vs_ph + 1) % vs_per;
            vsync_in = (vs_ph >= 3);
        end else begin
            vsync_in = vs_man;
        end
    endtask

    task automatic compare();
        chk("fb_clear_out", fb_if.fb_clear_out, m_clr);
        chk("fb_switch_out", fb_if.fb_switch_out, m_sw);
        chk("render_start_out", fb_if.render_start_out, m_start);
        chk("busy_out", busy_out, m_phase != P_IDLE);
        chk("frame_count_out", frame_count_out, m_frames);
        chk("dropped_count_out", dropped_count_out, m_drops);
        if (fb_if.fb_switch_out) switches++;
    endtask

    task automatic step();
        drive_inputs();
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic wait_phase(int p, int budget, string name);
        int n = 0;
        while (m_phase != p && n < budget) begin step(); n++; end
        if (m_phase != p) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic vsync_until_switch(string name);
        int n = 0;
        vs_man = 0;
        do begin step(); n++; end while (!fb_if.fb_switch_out && n < 20);
        chk({name, "_switch_latency"}, n, SS + 2);
        vs_man = 1;
    endtask

    initial begin
        int n, nclr;
        fb_if.fb_ready_in = 1'b1;
        fb_if.render_done_in = 1'b0;
        @(negedge clk);

        // Reset held with enable high and vsync toggling
        rst_n_in = 0; enable_in = 1; vs_auto = 1; vs_per = 4;
        repeat (6) step();
        chk("reset_busy", busy_out, 0);
        chk("reset_frames", frame_count_out, 0);
        chk("reset_drops", dropped_count_out, 0);
        chk("reset_clear", fb_if.fb_clear_out, 0);
        vs_auto = 0; vs_man = 1; enable_in = 0; rst_n_in = 1;
        repeat (6) step();
        chk("idle_busy", busy_out, 0);

        // Nominal frame
        enable_in = 1; rd_len = 5; done_dly = 20;
        wait_phase(P_WAIT, 200, "nominal_wait");
        chk("nominal_frames_before", frame_count_out, 0);
        vsync_until_switch("nominal");
        chk("nominal_frames_after", frame_count_out, 1);
        step();
        chk("nominal_clear_after_switch", fb_if.fb_clear_out, 1);

        // Overrun: two vblanks while rendering
        done_dly = 60;
        wait_phase(P_RENDER, 50, "overrun_render");
        repeat (2) begin
            vs_man = 0; repeat (3) step();
            vs_man = 1; repeat (5) step();
        end
        chk("overrun_drops", dropped_count_out, 2);
        wait_phase(P_WAIT, 100, "overrun_wait");
        repeat (10) step();
        chk("overrun_no_switch", frame_count_out, 1);
        vsync_until_switch("overrun");
        chk("overrun_frames", frame_count_out, 2);

        // Disable during render: frame completes then idles
        wait_phase(P_RENDER, 100, "disable_render");
        enable_in = 0;
        wait_phase(P_WAIT, 100, "disable_wait");
        vsync_until_switch("disable");
        chk("disable_frames", frame_count_out, 3);
        repeat (3) step();
        chk("disable_busy", busy_out, 0);
        vs_auto = 1; vs_per = 10; nclr = 0;
        repeat (30) begin step(); nclr += fb_if.fb_clear_out; end
        chk("disable_no_clear", nclr, 0);
        chk("disable_drops_kept", dropped_count_out, 2);

        // Wrap after 17 frames, then saturate the drop counter
        enable_in = 1; rd_len = 2; done_dly = 3; vs_per = 15; n = 0;
        while (switches < 17 && n < 3000) begin step(); n++; end
        chk("wrap_switches", switches, 17);
        chk("wrap_frames", frame_count_out, 1);
        done_dly = 200;
        wait_phase(P_RENDER, 100, "sat_render");
        vs_per = 8;
        repeat (180) step();
        chk("sat_drops", dropped_count_out, CMAX);

        // Reset while waiting for clear to finish
        done_dly = 10; rd_len = 10; vs_per = 20;
        wait_phase(P_CLEAR_WAIT, 600, "rst_clear_wait");
        repeat (2) step();
        vs_auto = 0; vs_man = 1;
        rst_n_in = 0;
        step();
        chk("midrst_busy", busy_out, 0);
        chk("midrst_frames", frame_count_out, 0);
        chk("midrst_drops", dropped_count_out, 0);
        step();
        rst_n_in = 1; enable_in = 1; n = 0;
        do begin step(); n++; end while (!fb_if.fb_clear_out && n < 10);
        chk("midrst_fresh_clear", fb_if.fb_clear_out, 1);
        chk("midrst_clear_latency", n, 4);
        chk("midrst_frames_after", frame_count_out, 0);

        // Randomized run
        noise = 1; vs_auto = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) enable_in = ($urandom_range(0, 9) != 0);
            rst_n_in = ($urandom_range(0, 999) != 0);
            rd_len = $urandom_range(1, 6);
            done_dly = $urandom_range(1, 60);
            done_level_mode = $urandom_range(0, 1);
            if (vs_ph == 0) vs_per = $urandom_range(10, 70);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
